range_text_parser: RTL

- Upstream front-end for the fresh-ingredient lookup stage.
- Consumes an ASCII byte stream in the puzzle format:
  - range section of "low-high\n" lines;
  - one blank line;
  - ID section of "id\n" lines.
- Each range is converted to a single-cycle FIFO write (low, high, fresh=1) gated by the lookup stage's fifo_ready.
- IDs are presented on a valid/ready stream for the downstream query sequencer.

---
 rtl/range_text_parser.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/range_text_parser.sv
// ASCII "low-high\n" / "id\n" stream parser feeding the range FIFO and the ID query stream.
// Optional macro STRICT_CHARSET_EN: an illegal character ends parsing (S_DONE) instead of being dropped.
module range_text_parser #(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              fifo_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] range_low,
    output logic [ADDR_W-1:0] range_high,
    output logic              range_fresh,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_value,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  range_count,
    output logic [CNT_W-1:0]  id_count,
    output logic              parse_err,
    output logic              done
);
    // Handshakes: a byte moves when byte_valid & byte_ready; an ID moves when id_valid & id_ready;
    // a range moves on the single wr_en cycle, which only occurs while fifo_ready is high.
    typedef enum logic [2:0] {S_LOW, S_HIGH, S_ID, S_EMIT_R, S_EMIT_ID, S_DONE} state_t;

    localparam logic [ADDR_W+3:0] MAX_V = {4'b0, {ADDR_W{1'b1}}};

    state_t            state, state_n;
    logic [ADDR_W-1:0] acc_a, acc_a_n, acc_b, acc_b_n;
    logic              seen, seen_n, last_seen, last_n;
    logic              err_set, illegal, latch_r, latch_id, range_inc, id_inc;
    logic              is_digit, is_nl, is_dash, is_cr;
    logic [ADDR_W+3:0] mac_wide;
    logic [ADDR_W-1:0] mac_val;
    logic              mac_ovf;

    assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    assign is_nl    = (byte_data == 8'h0A);
    assign is_dash  = (byte_data == 8'h2D);
    assign is_cr    = (byte_data == 8'h0D);

    // acc_a holds the low bound or the ID, acc_b the high bound.
    assign mac_wide = {4'b0, (state == S_HIGH) ? acc_b : acc_a} * (ADDR_W+4)'(10)
                    + {{ADDR_W{1'b0}}, byte_data[3:0]};
    assign mac_ovf  = mac_wide > MAX_V;
    assign mac_val  = mac_ovf ? {ADDR_W{1'b1}} : mac_wide[ADDR_W-1:0];

    assign byte_ready  = !rst && (state == S_LOW || state == S_HIGH || state == S_ID);
    assign wr_en       = !rst && (state == S_EMIT_R) && fifo_ready;
    assign id_valid    = (state == S_EMIT_ID);
    assign done        = (state == S_DONE);
    assign range_fresh = 1'b1;

    always_comb begin
        state_n   = state;
        acc_a_n   = acc_a;
        acc_b_n   = acc_b;
        seen_n    = seen;
        last_n    = last_seen;
        err_set   = 1'b0;
        illegal   = 1'b0;
        latch_r   = 1'b0;
        latch_id  = 1'b0;
        range_inc = 1'b0;
        id_inc    = 1'b0;
        case (state)
            S_LOW, S_HIGH, S_ID: begin
                if (byte_valid) begin
                    if (!is_cr) begin
                        if (is_digit) begin
                            if (state == S_HIGH) acc_b_n = mac_val;
                            else                 acc_a_n = mac_val;
                            seen_n  = 1'b1;
                            err_set = mac_ovf;
                        end else if (state == S_LOW) begin
                            if (is_dash && seen) begin
                                state_n = S_HIGH;
                                seen_n  = 1'b0;
                            end else if (is_nl && !seen) begin
                                state_n = S_ID;
                            end else begin
                                illegal = 1'b1;
                                if (is_nl) begin
                                    acc_a_n = '0;
                                    seen_n  = 1'b0;
                                end
                            end
                        end else if (state == S_HIGH) begin
                            if (is_nl && seen) begin
                                latch_r = 1'b1;
                                state_n = S_EMIT_R;
                            end else begin
                                illegal = 1'b1;
                            end
                        end else begin
                            if (is_nl && seen) begin
                                latch_id = 1'b1;
                                state_n  = S_EMIT_ID;
                            end else if (!is_nl) begin
                                illegal = 1'b1;
                            end
                        end
                    end
                    if (illegal) begin
                        err_set = 1'b1;
`ifdef STRICT_CHARSET_EN
                        state_n = S_DONE;
`endif
                    end
                    // End of stream is resolved against the state the byte itself produced.
                    if (byte_last && state_n != S_DONE) begin
                        last_n = 1'b1;
                        if (state_n == S_ID && seen_n) begin
                            latch_id = 1'b1;
                            state_n  = S_EMIT_ID;
                        end else if (state_n == S_HIGH || (state_n == S_LOW && seen_n)) begin
                            err_set = 1'b1;
                            state_n = S_DONE;
                        end else if (state_n != S_EMIT_R && state_n != S_EMIT_ID) begin
                            state_n = S_DONE;
                        end
                    end
                end
            end
            S_EMIT_R: begin
                if (fifo_ready) begin
                    range_inc = 1'b1;
                    acc_a_n   = '0;
                    acc_b_n   = '0;
                    seen_n    = 1'b0;
                    state_n   = last_seen ? S_DONE : S_LOW;
                end
            end
            S_EMIT_ID: begin
                if (id_ready) begin
                    id_inc  = 1'b1;
                    acc_a_n = '0;
                    seen_n  = 1'b0;
                    state_n = last_seen ? S_DONE : S_ID;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOW;
            acc_a       <= '0;
            acc_b       <= '0;
            seen        <= 1'b0;
            last_seen   <= 1'b0;
            range_low   <= '0;
            range_high  <= '0;
            id_value    <= '0;
            range_count <= '0;
            id_count    <= '0;
            parse_err   <= 1'b0;
        end else begin
            state     <= state_n;
            acc_a     <= acc_a_n;
            acc_b     <= acc_b_n;
            seen      <= seen_n;
            last_seen <= last_n;
            if (err_set) parse_err <= 1'b1;
            // Swapped bounds keep the downstream address walk finite.
            if (latch_r) begin
                if (acc_a > acc_b) begin
                    range_low  <= acc_b;
                    range_high <= acc_a;
                end else begin
                    range_low  <= acc_a;
                    range_high <= acc_b;
                end
            end
            if (latch_id) id_value <= acc_a_n;
            if (range_inc && range_count != {CNT_W{1'b1}}) range_count <= range_count + CNT_W'(1);
            if (id_inc && id_count != {CNT_W{1'b1}}) id_count <= id_count + CNT_W'(1);
        end
    end
endmodule
